spi_flash_responder: RTL

Synthesizable SPI NOR-flash emulator: the responder end of the flash link that the bootloader's control endpoint drives as SPI master. It oversamples the SPI pins on the 48 MHz system clock, decodes the flash command subset the bootloader issues, and serves reads and page programs from an external synchronous RAM. It is used for board-level bring-up and as the flash model in bootloader system simulation.

---
 rtl/spi_flash_pkg.sv | 42 ++++
 rtl/spi_flash_responder_pin_sync.sv | 38 +++
 rtl/spi_flash_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, FSM states,
// status register layout and the JEDEC ID byte selector.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_RES   = 8'hAB;
    localparam logic [7:0] CMD_DP    = 8'hB9;

    localparam int STS_WIP = 0;
    localparam int STS_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA_OUT,
        ST_DATA_IN,
        ST_IGNORE
    } flash_state_e;

    // Where the next response byte comes from when its first bit is driven.
    typedef enum logic [1:0] {
        SRC_REG,
        SRC_STATUS,
        SRC_MEM
    } tx_src_e;

    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            2'd2:    return id[7:0];
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection on SCK and CS.
module spi_pin_sync (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_s
);

    // [1] is the synchronized sample, [2] its previous value for edge detect
    logic [2:0] sck_sr;
    logic [2:0] cs_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sck_sr  <= 3'b000;
            cs_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sck_sr  <= {sck_sr[1:0], spi_sck};
            cs_sr   <= {cs_sr[1:0], spi_cs};
            mosi_sr <= {mosi_sr[0], spi_mosi};
        end
    end

    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] & sck_sr[2];
    assign cs_rise  = cs_sr[1] & ~cs_sr[2];
    assign cs_fall  = ~cs_sr[1] & cs_sr[2];
    assign mosi_s   = mosi_sr[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash emulator: decodes READ/PP/RDSR/WREN/WRDI/JEDEC on an
// oversampled SPI link and serves data from an external synchronous RAM.
import spi_flash_pkg::*;

module spi_flash_responder #(
    parameter int          ADDR_W      = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          BUSY_CYCLES = 480
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we
);

    localparam int BW = $clog2(BUSY_CYCLES + 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

    spi_pin_sync u_pin_sync (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .mosi_s    (mosi_s)
    );

    flash_state_e      state;
    tx_src_e           tx_src;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [7:0]        tx_sr, tx_next, tx_load, status;
    logic [1:0]        addr_cnt, id_idx;
    logic [ADDR_W-9:0] addr_sr;
    logic [ADDR_W-1:0] addr_full, rd_addr;
    logic [ADDR_W-9:0] pp_page;
    logic [7:0]        pp_off;
    logic              is_read, pend_wren, pend_wrdi, pp_wrote;
    logic              wel, wip;
    logic [BW-1:0]     busy_cnt;

    assign rx_byte   = {rx_sr, mosi_s};
    assign addr_full = {addr_sr, rx_byte};
    // CS rise in the same cycle as the 8th SCK rise discards the byte
    assign byte_done = (state != ST_IDLE) && sck_rise && !cs_rise && (bit_cnt == 3'd7);

    always_comb begin
        status          = '0;
        status[STS_WEL] = wel;
        status[STS_WIP] = wip;
    end

    always_comb begin
        tx_load = tx_next;
        case (tx_src)
            SRC_MEM:    tx_load = mem_rdata;
            SRC_STATUS: tx_load = status;
            default:    tx_load = tx_next;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx_src    <= SRC_REG;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= 8'hFF;
            tx_next   <= 8'hFF;
            addr_cnt  <= '0;
            id_idx    <= '0;
            addr_sr   <= '0;
            rd_addr   <= '0;
            pp_page   <= '0;
            pp_off    <= '0;
            is_read   <= 1'b0;
            pend_wren <= 1'b0;
            pend_wrdi <= 1'b0;
            pp_wrote  <= 1'b0;
            wel       <= 1'b0;
            wip       <= 1'b0;
            busy_cnt  <= '0;
            spi_miso  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == BW'(1))
                    wip <= 1'b0;
            end

            if (cs_rise) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b1;
                if (pp_wrote) begin
                    wel      <= 1'b0;
                    wip      <= 1'b1;
                    busy_cnt <= BW'(BUSY_CYCLES);
                end else if (pend_wren) begin
                    wel <= 1'b1;
                end else if (pend_wrdi) begin
                    wel <= 1'b0;
                end
                pp_wrote  <= 1'b0;
                pend_wren <= 1'b0;
                pend_wrdi <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (cs_fall) begin
                    state   <= ST_CMD;
                    bit_cnt <= '0;
                end
            end else begin
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                // The first fall of a byte picks up the freshly prepared byte
                if (sck_fall && state == ST_DATA_OUT) begin
                    if (bit_cnt == 3'd0) begin
                        spi_miso <= tx_load[7];
                        tx_sr    <= {tx_load[6:0], 1'b1};
                    end else begin
                        spi_miso <= tx_sr[7];
                        tx_sr    <= {tx_sr[6:0], 1'b1};
                    end
                end

                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (wip && rx_byte != CMD_RDSR) begin
                                state <= ST_IGNORE;
                            end else begin
                                case (rx_byte)
                                    CMD_JEDEC: begin
                                        state   <= ST_DATA_OUT;
                                        tx_src  <= SRC_REG;
                                        tx_next <= jedec_byte(JEDEC_ID, 2'd0);
                                        id_idx  <= 2'd1;
                                    end
                                    CMD_RDSR: begin
                                        state  <= ST_DATA_OUT;
                                        tx_src <= SRC_STATUS;
                                    end
                                    CMD_WREN: begin
                                        pend_wren <= 1'b1;
                                        state     <= ST_IGNORE;
                                    end
                                    CMD_WRDI: begin
                                        pend_wrdi <= 1'b1;
                                        state     <= ST_IGNORE;
                                    end
                                    CMD_READ: begin
                                        is_read  <= 1'b1;
                                        addr_cnt <= '0;
                                        state    <= ST_ADDR;
                                    end
                                    CMD_PP: begin
                                        is_read  <= 1'b0;
                                        addr_cnt <= '0;
                                        state    <= wel ? ST_ADDR : ST_IGNORE;
                                    end
                                    CMD_RES, CMD_DP: state <= ST_IGNORE;
                                    default:         state <= ST_IGNORE;
                                endcase
                            end
                        end
                        ST_ADDR: begin
                            addr_sr  <= (ADDR_W-8)'({addr_sr, rx_byte});
                            addr_cnt <= addr_cnt + 2'd1;
                            if (addr_cnt == 2'd2) begin
                                if (is_read) begin
                                    mem_addr <= addr_full;
                                    rd_addr  <= addr_full + 1'b1;
                                    tx_src   <= SRC_MEM;
                                    state    <= ST_DATA_OUT;
                                end else begin
                                    pp_page <= addr_full[ADDR_W-1:8];
                                    pp_off  <= addr_full[7:0];
                                    state   <= ST_DATA_IN;
                                end
                            end
                        end
                        ST_DATA_OUT: begin
                            if (tx_src == SRC_MEM) begin
                                mem_addr <= rd_addr;
                                rd_addr  <= rd_addr + 1'b1;
                            end else if (tx_src == SRC_REG) begin
                                tx_next <= jedec_byte(JEDEC_ID, id_idx);
                                if (id_idx != 2'd3)
                                    id_idx <= id_idx + 2'd1;
                            end
                        end
                        ST_DATA_IN: begin
                            mem_we    <= 1'b1;
                            mem_wdata <= rx_byte;
                            mem_addr  <= {pp_page, pp_off};
                            pp_off    <= pp_off + 8'd1;
                            pp_wrote  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
